// File: rtl/idp_sequencer_pkg.sv
// Shared definitions for the integer-datapath sequencer:
// state encoding, instruction field positions and the decoded control bundle.
package idp_sequencer_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned FOP_W   = 4;   // opcode field width in the instruction
  localparam int unsigned FADR_W  = 3;   // register field width in the instruction
  localparam int unsigned IMM_W   = 5;

  localparam int unsigned CLASS_B = 15;
  localparam int unsigned OP_HI   = 14;
  localparam int unsigned OP_LO   = 11;
  localparam int unsigned W_HI    = 10;
  localparam int unsigned W_LO    = 8;
  localparam int unsigned R_HI    = 7;
  localparam int unsigned R_LO    = 5;
  localparam int unsigned S_HI    = 4;
  localparam int unsigned S_LO    = 2;
  localparam int unsigned IMM_HI  = 4;
  localparam int unsigned IMM_LO  = 0;
  localparam int unsigned NW_B    = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2
  } state_t;

  typedef struct packed {
    logic [FOP_W-1:0]  alu_op;
    logic [FADR_W-1:0] w_adr;
    logic [FADR_W-1:0] r_adr;
    logic [FADR_W-1:0] s_adr;
    logic              s_sel;
    logic              wr_req;
  } ctl_t;

endpackage

// File: rtl/idp_sequencer_decode.sv
// Combinational instruction decoder.
// Ports: ir (instruction word) -> ctl (opcode, addresses, S select, write request),
//        ds (sign-extended immediate, zero for register-class words).
module idp_sequencer_decode
  import idp_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [INSTR_W-1:0] ir,
  output ctl_t               ctl,
  output logic [DATA_W-1:0]  ds
);

  // bit 1 of a register-class word carries no meaning
  logic unused_ir_b1;
  assign unused_ir_b1 = ir[1];

  always_comb begin
    ctl        = '0;
    ds         = '0;
    ctl.alu_op = ir[OP_HI:OP_LO];
    ctl.w_adr  = ir[W_HI:W_LO];
    ctl.r_adr  = ir[R_HI:R_LO];
    if (ir[CLASS_B]) begin
      ctl.s_sel  = 1'b1;
      ctl.wr_req = 1'b1;
      ds         = {{(DATA_W-IMM_W){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};
    end else begin
      ctl.s_adr  = ir[S_HI:S_LO];
      ctl.wr_req = ~ir[NW_B];
    end
  end

endmodule

// File: rtl/idp_sequencer.sv
// Three-state control unit for the register-file / S-mux / ALU datapath.
// Ports: clk, reset (sync, active high); instr_valid/instr/instr_ready handshake;
//        datapath controls W_En, W_Adr, R_Adr, S_Adr, S_Sel, DS, ALU_OP;
//        ALU flags C/N/Z in; flags, busy, done, instr_count status out.
module idp_sequencer
  import idp_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADR_W  = 3,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic              W_En,
  output logic [ADR_W-1:0]  W_Adr,
  output logic [ADR_W-1:0]  R_Adr,
  output logic [ADR_W-1:0]  S_Adr,
  output logic              S_Sel,
  output logic [DATA_W-1:0] DS,
  output logic [OP_W-1:0]   ALU_OP,
  input  logic              C,
  input  logic              N,
  input  logic              Z,
  output logic [2:0]        flags,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  instr_count
);

  state_t              state, state_d;
  logic [INSTR_W-1:0]  ir, ir_d;
  ctl_t                ctl;
  logic [DATA_W-1:0]   ds_dec;

  logic                active_d, w_en_d, w_en_q, s_sel_d, done_d;
  logic [ADR_W-1:0]    w_adr_d, r_adr_d, s_adr_d;
  logic [DATA_W-1:0]   ds_d;
  logic [OP_W-1:0]     alu_op_d;

  // decode the IR value that will hold after this edge so the controls can be registered
  idp_sequencer_decode #(.DATA_W(DATA_W)) u_decode (
    .ir  (ir_d),
    .ctl (ctl),
    .ds  (ds_dec)
  );

  // next state and IR capture
  always_comb begin
    state_d = state;
    ir_d    = ir;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          state_d = DECODE;
          ir_d    = instr;
        end
      end
      DECODE:  state_d = EXECUTE;
      EXECUTE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values of the registered control outputs
  always_comb begin
    active_d = (state_d != IDLE);
    w_en_d   = (state_d == EXECUTE) && ctl.wr_req;
    w_adr_d  = '0;
    r_adr_d  = '0;
    s_adr_d  = '0;
    s_sel_d  = 1'b0;
    ds_d     = '0;
    alu_op_d = '0;
    done_d   = (state == EXECUTE);
    if (active_d) begin
      w_adr_d  = ADR_W'(ctl.w_adr);
      r_adr_d  = ADR_W'(ctl.r_adr);
      s_adr_d  = ADR_W'(ctl.s_adr);
      s_sel_d  = ctl.s_sel;
      ds_d     = ds_dec;
      alu_op_d = OP_W'(ctl.alu_op);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ir          <= '0;
      instr_ready <= 1'b1;
      w_en_q      <= 1'b0;
      W_Adr       <= '0;
      R_Adr       <= '0;
      S_Adr       <= '0;
      S_Sel       <= 1'b0;
      DS          <= '0;
      ALU_OP      <= '0;
      flags       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_d;
      ir          <= ir_d;
      instr_ready <= ~active_d;
      w_en_q      <= w_en_d;
      W_Adr       <= w_adr_d;
      R_Adr       <= r_adr_d;
      S_Adr       <= s_adr_d;
      S_Sel       <= s_sel_d;
      DS          <= ds_d;
      ALU_OP      <= alu_op_d;
      busy        <= active_d;
      done        <= done_d;
      if (state == EXECUTE) begin
        flags       <= {C, N, Z};
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  // a reset landing on the write edge must keep the register file untouched
  assign W_En = w_en_q & ~reset;

endmodule

// File: tb/tb_idp_sequencer.sv
// Directed bench for idp_sequencer with a behavioural register file and ADD/SUB ALU.
module tb_idp_sequencer;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready, W_En, S_Sel, busy, done;
  logic [2:0]  W_Adr, R_Adr, S_Adr, flags;
  logic [15:0] DS, instr_count;
  logic [3:0]  ALU_OP;
  logic        c_f, n_f, z_f;

  logic        v2 = 1'b0;
  logic [15:0] i2 = '0;
  logic        r2, we2, ssel2, busy2, done2;
  logic [2:0]  wa2, ra2, sa2, fl2;
  logic [15:0] ds2;
  logic [3:0]  op2;
  logic [1:0]  cnt2;

  logic [15:0] rf [8];
  logic        rf_clear = 1'b1;
  logic [15:0] a_op, b_op;
  logic [16:0] sum;
  int          wr_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  idp_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .W_En(W_En), .W_Adr(W_Adr), .R_Adr(R_Adr),
    .S_Adr(S_Adr), .S_Sel(S_Sel), .DS(DS), .ALU_OP(ALU_OP),
    .C(c_f), .N(n_f), .Z(z_f), .flags(flags), .busy(busy), .done(done),
    .instr_count(instr_count)
  );

  idp_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .instr_valid(v2), .instr(i2),
    .instr_ready(r2), .W_En(we2), .W_Adr(wa2), .R_Adr(ra2),
    .S_Adr(sa2), .S_Sel(ssel2), .DS(ds2), .ALU_OP(op2),
    .C(1'b0), .N(1'b0), .Z(1'b0), .flags(fl2), .busy(busy2), .done(done2),
    .instr_count(cnt2)
  );

  // datapath model: operands read combinationally, write on the rising edge
  always_comb begin
    a_op = rf[R_Adr];
    b_op = S_Sel ? DS : rf[S_Adr];
    if (ALU_OP == OP_SUB) sum = {1'b0, a_op} + {1'b0, ~b_op} + 17'd1;
    else                  sum = {1'b0, a_op} + {1'b0, b_op};
    c_f = sum[16];
    n_f = sum[15];
    z_f = (sum[15:0] == 16'd0);
  end

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (W_En) begin
      rf[W_Adr] <= sum[15:0];
      wr_cnt    <= wr_cnt + 1;
    end
  end

  function automatic logic [15:0] reg_i(input logic [3:0] op, input logic [2:0] w,
                                        input logic [2:0] r, input logic [2:0] s, input logic nw);
    return {1'b0, op, w, r, s, 1'b0, nw};
  endfunction

  function automatic logic [15:0] imm_i(input logic [3:0] op, input logic [2:0] w,
                                        input logic [2:0] r, input logic [4:0] imm);
    return {1'b1, op, w, r, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a word and return #1 after its accepting edge (DECODE cycle)
  task automatic accept(input logic [15:0] w);
    instr       = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 10 && instr_ready !== 1'b1; i++) tick();
    vectors++;
    if (instr_ready !== 1'b1) begin
      $display("FAIL accept_timeout instr_ready=%b required=1", instr_ready);
      miscompares++;
    end
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic retire(input logic [15:0] w);
    accept(w);
    tick();
    tick();
  endtask

  task automatic test_reset();
    vectors++;
    if ({instr_ready, W_En, busy, done} !== 4'b1000) begin
      $display("FAIL reset_handshake {ready,wen,busy,done}=%b required=1000",
               {instr_ready, W_En, busy, done});
      miscompares++;
    end
    vectors++;
    if ({W_Adr, R_Adr, S_Adr, S_Sel, DS, ALU_OP} !== 30'd0) begin
      $display("FAIL reset_controls value=%h required=0", {W_Adr, R_Adr, S_Adr, S_Sel, DS, ALU_OP});
      miscompares++;
    end
    vectors++;
    if (flags !== 3'b000 || instr_count !== 16'd0) begin
      $display("FAIL reset_status flags=%b count=%0d required 000/0", flags, instr_count);
      miscompares++;
    end
  endtask

  task automatic preload();
    retire(imm_i(OP_ADD, 3'd1, 3'd0, 5'd5));
    retire(imm_i(OP_ADD, 3'd2, 3'd0, 5'd3));
    retire(imm_i(OP_ADD, 3'd4, 3'd0, 5'd7));
    retire(imm_i(OP_ADD, 3'd5, 3'd0, 5'd7));
    vectors++;
    if (rf[1] !== 16'd5 || rf[2] !== 16'd3 || instr_count !== 16'd4) begin
      $display("FAIL preload r1=%0d r2=%0d count=%0d required 5/3/4", rf[1], rf[2], instr_count);
      miscompares++;
    end
  endtask

  task automatic test_reg_add();
    accept(reg_i(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0));
    // a second word offered while busy must be ignored
    instr       = imm_i(OP_SUB, 3'd7, 3'd6, 5'd9);
    instr_valid = 1'b1;
    vectors++;
    if ({W_En, busy, instr_ready, done} !== 4'b0100) begin
      $display("FAIL add_decode_hs {wen,busy,ready,done}=%b required=0100", {W_En, busy, instr_ready, done});
      miscompares++;
    end
    vectors++;
    if ({ALU_OP, W_Adr, R_Adr, S_Adr, S_Sel} !== {OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0}) begin
      $display("FAIL add_decode_fields value=%h required=%h", {ALU_OP, W_Adr, R_Adr, S_Adr, S_Sel},
               {OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0});
      miscompares++;
    end
    tick();
    vectors++;
    if ({W_En, busy, instr_ready, done, W_Adr, ALU_OP} !== {4'b1100, 3'd3, OP_ADD}) begin
      $display("FAIL add_execute value=%h required=%h", {W_En, busy, instr_ready, done, W_Adr, ALU_OP},
               {4'b1100, 3'd3, OP_ADD});
      miscompares++;
    end
    tick();
    instr_valid = 1'b0;
    vectors++;
    if ({W_En, busy, instr_ready, done} !== 4'b0011) begin
      $display("FAIL add_done {wen,busy,ready,done}=%b required=0011", {W_En, busy, instr_ready, done});
      miscompares++;
    end
    vectors++;
    if (rf[3] !== 16'd8 || flags !== 3'b000 || instr_count !== 16'd5 || rf[7] !== 16'd0) begin
      $display("FAIL add_result r3=%0d flags=%b count=%0d r7=%0d required 8/000/5/0",
               rf[3], flags, instr_count, rf[7]);
      miscompares++;
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL add_done_pulse done=%b busy=%b required 0/0", done, busy);
      miscompares++;
    end
  endtask

  task automatic test_neg_imm();
    accept(imm_i(OP_ADD, 3'd6, 3'd1, 5'b11110));
    vectors++;
    if ({DS, S_Sel, S_Adr, W_Adr, R_Adr} !== {16'hFFFE, 1'b1, 3'd0, 3'd6, 3'd1}) begin
      $display("FAIL neg_imm_decode value=%h required=%h", {DS, S_Sel, S_Adr, W_Adr, R_Adr},
               {16'hFFFE, 1'b1, 3'd0, 3'd6, 3'd1});
      miscompares++;
    end
    tick();
    tick();
    vectors++;
    if (rf[6] !== 16'd3 || flags !== 3'b100) begin
      $display("FAIL neg_imm_pos r6=%h flags=%b required 0003/100", rf[6], flags);
      miscompares++;
    end
    retire(imm_i(OP_ADD, 3'd7, 3'd0, 5'b11110));
    vectors++;
    if (rf[7] !== 16'hFFFE || flags !== 3'b010) begin
      $display("FAIL neg_imm_neg r7=%h flags=%b required fffe/010", rf[7], flags);
      miscompares++;
    end
  endtask

  task automatic test_nw_compare();
    logic [15:0] cnt0;
    int          wr0;
    cnt0 = instr_count;
    wr0  = wr_cnt;
    accept(reg_i(OP_SUB, 3'd4, 3'd4, 3'd5, 1'b1));
    vectors++;
    if (W_En !== 1'b0) begin
      $display("FAIL nw_decode_wen W_En=%b required=0", W_En);
      miscompares++;
    end
    tick();
    vectors++;
    if (W_En !== 1'b0) begin
      $display("FAIL nw_execute_wen W_En=%b required=0", W_En);
      miscompares++;
    end
    tick();
    vectors++;
    if (rf[4] !== 16'd7 || wr_cnt != wr0 || flags !== 3'b101 || instr_count !== 16'(cnt0 + 16'd1)) begin
      $display("FAIL nw_result r4=%0d writes=%0d flags=%b count=%0d required 7/%0d/101/%0d",
               rf[4], wr_cnt, flags, instr_count, wr0, cnt0 + 16'd1);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [3];
    int          idx, ready_hi, bad_slot, wr0;
    logic        acc;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    prog[0] = imm_i(OP_ADD, 3'd1, 3'd0, 5'd9);
    prog[1] = imm_i(OP_ADD, 3'd2, 3'd0, 5'd4);
    prog[2] = reg_i(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
    idx = 0; ready_hi = 0; bad_slot = 0; wr0 = wr_cnt;
    instr       = prog[0];
    instr_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (instr_ready === 1'b1) begin
        ready_hi++;
        if (c % 3 != 0) bad_slot++;
      end
      acc = instr_ready & instr_valid;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) instr = prog[idx];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    vectors++;
    if (ready_hi != 3 || bad_slot != 0 || idx != 3) begin
      $display("FAIL b2b_ready ready_high=%0d off_slot=%0d accepted=%0d required 3/0/3", ready_hi, bad_slot, idx);
      miscompares++;
    end
    vectors++;
    if (wr_cnt - wr0 != 3 || instr_count !== 16'd3 || rf[3] !== 16'd13) begin
      $display("FAIL b2b_result writes=%0d count=%0d r3=%0d required 3/3/13", wr_cnt - wr0, instr_count, rf[3]);
      miscompares++;
    end
  endtask

  task automatic test_reset_in_execute();
    retire(imm_i(OP_ADD, 3'd7, 3'd0, 5'b11110));
    vectors++;
    if (flags !== 3'b010 || instr_count !== 16'd4) begin
      $display("FAIL rst_exec_setup flags=%b count=%0d required 010/4", flags, instr_count);
      miscompares++;
    end
    accept(imm_i(OP_ADD, 3'd5, 3'd0, 5'd3));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (rf[5] !== 16'd7) begin
      $display("FAIL rst_exec_nowrite r5=%0d required=7", rf[5]);
      miscompares++;
    end
    vectors++;
    if ({instr_ready, busy, W_En, done, flags} !== 7'b1000_000 || instr_count !== 16'd0) begin
      $display("FAIL rst_exec_state {ready,busy,wen,done,flags}=%b count=%0d required 1000000/0",
               {instr_ready, busy, W_En, done, flags}, instr_count);
      miscompares++;
    end
  endtask

  task automatic test_counter_wrap();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;
    for (int n = 0; n < 5; n++) begin
      i2 = imm_i(OP_ADD, 3'd1, 3'd0, 5'd1);
      v2 = 1'b1;
      for (int i = 0; i < 10 && r2 !== 1'b1; i++) tick();
      tick();
      v2 = 1'b0;
      tick();
      tick();
      vectors++;
      if (cnt2 !== exp_cnt[n]) begin
        $display("FAIL wrap_count_%0d count=%0d required=%0d", n + 1, cnt2, exp_cnt[n]);
        miscompares++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    rf_clear = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    rf_clear = 1'b0;
    test_reset();
    preload();
    test_reg_add();
    test_neg_imm();
    test_nw_compare();
    test_back_to_back();
    test_reset_in_execute();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
